// File: rtl/mm_write_arbiter.sv
// -----------------------------------------------------------------------------
// mm_write_arbiter
//
// Shares the single matrix-memory write port among num_req_p executors.
// A round-robin pick accepts one request at a time, captures its address and
// 4x4 data, strobes the memory once, waits for the memory to report ready and
// then pulses done back to the granted executor.
//
// Parameters:
//   num_req_p  number of requesters (>=1); index 0 wins first after reset
//   width_p    board width  (sizes the x field of point_t)
//   height_p   board height (sizes the y field of point_t)
//   debug_p    1 = enable simulation-time one-hot checks on ready/done pulses
//
// Ports:
//   clk_i            clock
//   reset_i          asynchronous reset, active-high
//   req_v_i          request valid per requester, held until req_ready_o
//   req_addr_i       write address per requester (point_t = {x, y})
//   req_data_i       4x4 write data per requester
//   req_ready_o      1-cycle pulse, request captured (one-hot or zero)
//   req_done_o       1-cycle pulse, that requester's write completed
//   mm_write_addr_o  captured address to the matrix memory
//   mm_write_data_o  captured data to the matrix memory
//   mm_write_v_o     1-cycle write strobe
//   mm_is_ready_i    memory finished the previous write
//   busy_o           a transaction is in flight
//   grant_id_o       index of the current/last grant
// -----------------------------------------------------------------------------
module mm_write_arbiter #(
    parameter int num_req_p = 3,
    parameter int width_p   = 16,
    parameter int height_p  = 32,
    parameter int debug_p   = 0,
    localparam int x_w_lp    = (width_p  > 1) ? $clog2(width_p)  : 1,
    localparam int y_w_lp    = (height_p > 1) ? $clog2(height_p) : 1,
    localparam int addr_w_lp = x_w_lp + y_w_lp,
    localparam int id_w_lp   = (num_req_p > 1) ? $clog2(num_req_p) : 1
) (
    input  logic                                 clk_i,
    input  logic                                 reset_i,
    input  logic [num_req_p-1:0]                 req_v_i,
    input  logic [num_req_p-1:0][addr_w_lp-1:0]  req_addr_i,
    input  logic [num_req_p-1:0][3:0][3:0]       req_data_i,
    output logic [num_req_p-1:0]                 req_ready_o,
    output logic [num_req_p-1:0]                 req_done_o,
    output logic [addr_w_lp-1:0]                 mm_write_addr_o,
    output logic [3:0][3:0]                      mm_write_data_o,
    output logic                                 mm_write_v_o,
    input  logic                                 mm_is_ready_i,
    output logic                                 busy_o,
    output logic [id_w_lp-1:0]                   grant_id_o
);

    typedef struct packed {
        logic [x_w_lp-1:0] x;
        logic [y_w_lp-1:0] y;
    } point_t;

    typedef enum logic [1:0] {
        eIDLE,
        eWrite,
        eWaiting,
        eDone
    } state_e;

    state_e             state;
    point_t             addr_r;
    logic [3:0][3:0]    data_r;
    logic [id_w_lp-1:0] grant_id;
    logic [id_w_lp-1:0] last_grant;

    logic               found;
    logic [id_w_lp-1:0] pick;
    int                 idx;

    // Round-robin search starting just after the last completed grant, so a
    // requester that was just served is ranked last among those pending.
    always_comb begin
        // NOTE: every always_comb output gets a default first; a path that
        // leaves one unassigned would infer a latch.
        found = 1'b0;
        pick  = '0;
        idx   = 0;
        for (int i = 1; i <= num_req_p; i++) begin
            idx = int'(last_grant) + i;
            if (idx >= num_req_p) begin
                idx = idx - num_req_p;
            end
            if (!found && req_v_i[id_w_lp'(idx)]) begin
                found = 1'b1;
                pick  = id_w_lp'(idx);
            end
        end
    end

    // Accept is combinational so the requester sees ready in the same cycle
    // its data is captured; gated by reset so all outputs are 0 while held.
    always_comb begin
        req_ready_o = '0;
        if (state == eIDLE && found && !reset_i) begin
            req_ready_o[pick] = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register samples the pre-edge value of every other register.
        if (reset_i) begin
            // NOTE: the capture registers are plain flops, not a memory array,
            // so resetting them is cheap and keeps the memory-side bus at 0.
            state        <= eIDLE;
            addr_r       <= '0;
            data_r       <= '0;
            grant_id     <= '0;
            last_grant   <= id_w_lp'(num_req_p - 1);
            mm_write_v_o <= 1'b0;
            req_done_o   <= '0;
            busy_o       <= 1'b0;
        end else begin
            mm_write_v_o <= 1'b0;
            req_done_o   <= '0;
            case (state)
                eIDLE: begin
                    if (found) begin
                        addr_r       <= point_t'(req_addr_i[pick]);
                        data_r       <= req_data_i[pick];
                        grant_id     <= pick;
                        mm_write_v_o <= 1'b1;
                        busy_o       <= 1'b1;
                        state        <= eWrite;
                    end
                end
                eWrite: begin
                    // Memory ready is not looked at here; it may still reflect
                    // the previous write.
                    state <= eWaiting;
                end
                eWaiting: begin
                    if (mm_is_ready_i) begin
                        req_done_o[grant_id] <= 1'b1;
                        state                <= eDone;
                    end
                end
                eDone: begin
                    last_grant <= grant_id;
                    busy_o     <= 1'b0;
                    state      <= eIDLE;
                end
                default: state <= eIDLE;
            endcase
        end
    end

    assign mm_write_addr_o = addr_r;
    assign mm_write_data_o = data_r;
    assign grant_id_o      = grant_id;

    if (debug_p != 0) begin : g_debug
        always_ff @(posedge clk_i) begin
            if (!reset_i) begin
                assert ($onehot0(req_ready_o) && $onehot0(req_done_o));
            end
        end
    end

endmodule

// File: tb/tb_mm_write_arbiter.sv
module tb_mm_write_arbiter;

    logic                 clk_i = 1'b0;
    logic                 reset_i;
    logic [2:0]           req_v_i;
    logic [2:0][8:0]      req_addr_i;
    logic [2:0][3:0][3:0] req_data_i;
    logic [2:0]           req_ready_o;
    logic [2:0]           req_done_o;
    logic [8:0]           mm_write_addr_o;
    logic [3:0][3:0]      mm_write_data_o;
    logic                 mm_write_v_o;
    logic                 mm_is_ready_i;
    logic                 busy_o;
    logic [1:0]           grant_id_o;

    int checks = 0;
    int errors = 0;

    mm_write_arbiter #(
        .num_req_p(3),
        .width_p  (16),
        .height_p (32),
        .debug_p  (1)
    ) dut (
        .clk_i          (clk_i),
        .reset_i        (reset_i),
        .req_v_i        (req_v_i),
        .req_addr_i     (req_addr_i),
        .req_data_i     (req_data_i),
        .req_ready_o    (req_ready_o),
        .req_done_o     (req_done_o),
        .mm_write_addr_o(mm_write_addr_o),
        .mm_write_data_o(mm_write_data_o),
        .mm_write_v_o   (mm_write_v_o),
        .mm_is_ready_i  (mm_is_ready_i),
        .busy_o         (busy_o),
        .grant_id_o     (grant_id_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [8:0] pt(input int x, input int y);
        logic [3:0] xb;
        logic [4:0] yb;
        xb = 4'(x);
        yb = 5'(y);
        return {xb, yb};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Packed view {ready[2:0], write_v, done[2:0], busy}.
    task automatic outs(input string tag, input logic [2:0] r, input logic w,
                        input logic [2:0] d, input logic b);
        check(tag, 32'({req_ready_o, mm_write_v_o, req_done_o, busy_o}),
              32'({r, w, d, b}));
    endtask

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic mid();
        @(negedge clk_i);
    endtask

    task automatic do_reset();
        mid();
        reset_i = 1'b1;
        cyc();
        cyc();
        reset_i = 1'b0;
    endtask

    initial begin
        reset_i       = 1'b1;
        req_v_i       = '0;
        req_addr_i    = '0;
        req_data_i    = '0;
        mm_is_ready_i = 1'b0;

        // Reset state.
        mid();
        outs("reset_outs", 3'b000, 1'b0, 3'b000, 1'b0);
        check("reset_addr", 32'(mm_write_addr_o), 32'h0);
        check("reset_data", 32'(mm_write_data_o), 32'h0);
        check("reset_grant", 32'(grant_id_o), 32'h0);

        // Single request (3,5)/0660; requester changes inputs after accept.
        cyc();
        reset_i       = 1'b0;
        req_v_i       = 3'b001;
        req_addr_i[0] = pt(3, 5);
        req_data_i[0] = 16'h0660;
        mm_is_ready_i = 1'b1;
        mid();
        outs("t1_accept", 3'b001, 1'b0, 3'b000, 1'b0);
        cyc();
        req_v_i       = 3'b000;
        req_addr_i[0] = pt(0, 0);
        req_data_i[0] = 16'hFFFF;
        mid();
        outs("t1_strobe", 3'b000, 1'b1, 3'b000, 1'b1);
        check("t1_addr", 32'(mm_write_addr_o), 32'h065);
        check("t1_data", 32'(mm_write_data_o), 32'h0660);
        cyc();
        mid();
        outs("t1_wait", 3'b000, 1'b0, 3'b000, 1'b1);
        cyc();
        mid();
        outs("t1_done", 3'b000, 1'b0, 3'b001, 1'b1);
        check("t6_addr_held", 32'(mm_write_addr_o), 32'h065);
        check("t6_data_held", 32'(mm_write_data_o), 32'h0660);
        cyc();
        mid();
        outs("t1_idle", 3'b000, 1'b0, 3'b000, 1'b0);

        // All three requesting continuously: grants 0,1,2,0,1, 4 cycles apart.
        do_reset();
        req_v_i       = 3'b111;
        mm_is_ready_i = 1'b1;
        for (int k = 0; k < 5; k++) begin
            logic [2:0] oh;
            oh = 3'b001 << (k % 3);
            mid();
            outs($sformatf("t2_accept%0d", k), oh, 1'b0, 3'b000, 1'b0);
            cyc();
            mid();
            outs($sformatf("t2_strobe%0d", k), 3'b000, 1'b1, 3'b000, 1'b1);
            check($sformatf("t2_grant%0d", k), 32'(grant_id_o), 32'(k % 3));
            cyc();
            mid();
            outs($sformatf("t2_wait%0d", k), 3'b000, 1'b0, 3'b000, 1'b1);
            cyc();
            mid();
            outs($sformatf("t2_done%0d", k), 3'b000, 1'b0, oh, 1'b1);
            cyc();
        end
        req_v_i = 3'b000;
        mid();
        outs("t2_idle", 3'b000, 1'b0, 3'b000, 1'b0);

        // Stalled memory; ready during the strobe cycle must be ignored.
        cyc();
        req_v_i       = 3'b100;
        mm_is_ready_i = 1'b0;
        mid();
        outs("t3_accept", 3'b100, 1'b0, 3'b000, 1'b0);
        cyc();
        req_v_i       = 3'b000;
        mm_is_ready_i = 1'b1;
        mid();
        outs("t3_strobe", 3'b000, 1'b1, 3'b000, 1'b1);
        cyc();
        mm_is_ready_i = 1'b0;
        for (int i = 0; i < 10; i++) begin
            mid();
            outs($sformatf("t3_stall%0d", i), 3'b000, 1'b0, 3'b000, 1'b1);
            cyc();
        end
        mm_is_ready_i = 1'b1;
        mid();
        outs("t3_ready_rise", 3'b000, 1'b0, 3'b000, 1'b1);
        cyc();
        mm_is_ready_i = 1'b0;
        mid();
        outs("t3_done", 3'b000, 1'b0, 3'b100, 1'b1);
        cyc();
        mid();
        outs("t3_idle", 3'b000, 1'b0, 3'b000, 1'b0);

        // req1 arrives while req0 busy; req0 re-requests right after done.
        cyc();
        req_v_i       = 3'b001;
        mm_is_ready_i = 1'b1;
        mid();
        outs("t4_accept0", 3'b001, 1'b0, 3'b000, 1'b0);
        cyc();
        req_v_i = 3'b010;
        mid();
        outs("t4_busy_block", 3'b000, 1'b1, 3'b000, 1'b1);
        cyc();
        mid();
        outs("t4_wait0", 3'b000, 1'b0, 3'b000, 1'b1);
        cyc();
        mid();
        outs("t4_done0", 3'b000, 1'b0, 3'b001, 1'b1);
        cyc();
        req_v_i       = 3'b011;
        req_addr_i[0] = pt(7, 9);
        req_data_i[0] = 16'h1234;
        mid();
        outs("t4_req1_first", 3'b010, 1'b0, 3'b000, 1'b0);
        cyc();
        req_v_i = 3'b001;
        mid();
        outs("t4_strobe1", 3'b000, 1'b1, 3'b000, 1'b1);
        check("t4_grant1", 32'(grant_id_o), 32'h1);
        cyc();
        cyc();
        mid();
        outs("t4_done1", 3'b000, 1'b0, 3'b010, 1'b1);
        cyc();
        mid();
        outs("t4_accept0_again", 3'b001, 1'b0, 3'b000, 1'b0);
        cyc();
        req_v_i       = 3'b000;
        mm_is_ready_i = 1'b0;
        mid();
        outs("t4_strobe0", 3'b000, 1'b1, 3'b000, 1'b1);
        check("t4_addr0", 32'(mm_write_addr_o), 32'(pt(7, 9)));
        cyc();
        mid();
        outs("t5_waiting", 3'b000, 1'b0, 3'b000, 1'b1);

        // Reset mid-wait: outputs drop at once, no done; req0 wins afterwards.
        req_v_i = 3'b111;
        reset_i = 1'b1;
        #1;
        outs("t5_reset_now", 3'b000, 1'b0, 3'b000, 1'b0);
        check("t5_reset_addr", 32'(mm_write_addr_o), 32'h0);
        check("t5_reset_grant", 32'(grant_id_o), 32'h0);
        cyc();
        mid();
        outs("t5_reset_held", 3'b000, 1'b0, 3'b000, 1'b0);
        cyc();
        reset_i       = 1'b0;
        mm_is_ready_i = 1'b1;
        mid();
        outs("t5_req0_first", 3'b001, 1'b0, 3'b000, 1'b0);
        cyc();
        req_v_i = 3'b000;
        mid();
        outs("t5_strobe", 3'b000, 1'b1, 3'b000, 1'b1);
        check("t5_grant0", 32'(grant_id_o), 32'h0);
        cyc();
        cyc();
        mid();
        outs("t5_done", 3'b000, 1'b0, 3'b001, 1'b1);
        cyc();
        mid();
        outs("t5_idle", 3'b000, 1'b0, 3'b000, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
